minmax_window_tracker: RTL and testbench
========================================

// Module: minmax_window_tracker
// PURPOSE
//  Sequential consumer of the 8-bit signed comparator's x/y/z flags (x: a>b, y: a==b, z: a<b, two's complement).
//  Accepts a stream of signed samples and reports the max and min of each window of WIN_LEN samples.
//  Time-multiplexes a single comparator: drives its a/b operands and consumes its flags in the same cycle.
//  Sits downstream of the comparator and upstream of any statistics/reporting logic.
// PARAMETERS
//  DATA_W   8   sample width; fixed to the comparator width, do not override
//  WIN_LEN  16  samples per window, legal range 1..255
//  CNT_W    8   localparam, window/tie counter width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_data    in   DATA_W  signed sample
//  in_valid   in   1       sample valid
//  in_ready   out  1       block can accept a sample
//  cmp_a      out  DATA_W  comparator operand a (always the held sample)
//  cmp_b      out  DATA_W  comparator operand b (current max or min)
//  cmp_x      in   1       comparator flag a>b
//  cmp_y      in   1       comparator flag a==b
//  cmp_z      in   1       comparator flag a<b
//  out_max    out  DATA_W  window maximum, meaningful while out_valid=1
//  out_min    out  DATA_W  window minimum, meaningful while out_valid=1
//  out_valid  out  1       window result available
//  out_ready  in   1       consumer accepts result
//  tie_cnt    out  CNT_W   samples equal to running max (see CONFIGURATION)
//  flag_err   out  1       sticky: comparator flags not one-hot during a compare
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=S_IDLE; max_r, min_r, smp_r, cnt, tie_cnt = 0; flag_err=0; out_valid=0.
//  - Handshakes: in transfer on in_valid&&in_ready; out transfer on out_valid&&out_ready. in_ready=1 only in S_IDLE/S_WAIT.
//  - cmp_a=smp_r always; cmp_b=min_r in S_CMP_MIN, else max_r. Comparator is combinational; flags sampled same cycle.
//  - FSM:
//    S_IDLE: on in transfer: max_r=min_r=smp_r=in_data, cnt=1; -> S_DONE if WIN_LEN==1, else S_WAIT.
//    S_WAIT: on in transfer: smp_r=in_data -> S_CMP_MAX; else stay.
//    S_CMP_MAX: if cmp_x, max_r<=smp_r -> S_CMP_MIN.
//    S_CMP_MIN: if cmp_z, min_r<=smp_r; cnt<=cnt+1; -> S_DONE if cnt+1==WIN_LEN, else S_WAIT.
//    S_DONE: out_valid=1, out_max/out_min hold; on out transfer -> S_IDLE, cnt=0, tie_cnt=0.
//  - Throughput: first sample 1 cycle, later samples 3 cycles each (accept, max, min); no sample dropped.
//  - Result latency: out_valid rises 2 cycles after accepting the WIN_LEN-th sample (1 cycle if WIN_LEN==1).
//  - Equal-to-extreme (cmp_y): no register update.
//  - out_valid held under back-pressure; out_max/out_min stable; in_ready=0 until released.
//  - flag_err set when state is S_CMP_MAX/S_CMP_MIN and {cmp_x,cmp_y,cmp_z} not one-hot; cleared only by reset;
//    max_r/min_r update rules still applied literally.
//  - Reset mid-window discards partial window; next window starts fresh from S_IDLE.
// CONFIGURATION
//  - Macro MINMAX_TIE_COUNT_EN defined: tie_cnt increments (saturating at 2^CNT_W-1) in S_CMP_MAX when cmp_y=1;
//    value valid with out_valid; cleared on out transfer.
//  - Macro undefined: no tie counter logic; tie_cnt tied to 0.
// STRUCTURE
//  - Shared package: state encoding (S_IDLE,S_WAIT,S_CMP_MAX,S_CMP_MIN,S_DONE), DATA_W=8, CNT_W constants.
//  - One sub-module: minmax_flag_check (one-hot check of x/y/z, produces sticky flag_err); rest is flat.
//  - Bench instantiates the real 8-bit signed comparator between cmp_a/cmp_b and cmp_x/y/z.
// TESTING
//  1. WIN_LEN=4, samples 5,-3,7,0 -> out_max=0x07, out_min=0xFD, out_valid 2 cycles after 4th accept.
//  2. WIN_LEN=4, samples 0x80 x4 -> out_max=out_min=0x80; tie_cnt=3 with macro, 0 without.
//  3. Result held, out_ready=0 for 10 cycles -> out_valid=1, values stable, in_ready=0; then release -> S_IDLE.
//  4. in_valid held high continuously -> in_ready pattern 1,1,0,0,1,0,0...; all 4 samples consumed, order kept.
//  5. rst_n low during S_CMP_MIN -> all outputs 0 immediately; next window 1,2,3,4 -> max=4, min=1.
//  6. Force cmp_x=cmp_z=1 in one compare cycle -> flag_err=1, stays 1 across windows until rst_n.

Source files
------------

// File: rtl/minmax_window_tracker_pkg.sv
// minmax_window_tracker_pkg: shared widths and FSM state encoding for the window tracker
package minmax_window_tracker_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMP_MAX, S_CMP_MIN, S_DONE} state_t;
endpackage

// File: rtl/minmax_window_tracker_flag_check.sv
// minmax_flag_check: sticky error when comparator flags are not one-hot during a compare
module minmax_flag_check (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic x,
  input  logic y,
  input  logic z,
  output logic err
);
  // latch any non-one-hot flag set seen while a compare is in progress
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (active && !$onehot({x, y, z})) err <= 1'b1;
endmodule

// File: rtl/minmax_window_tracker.sv
// minmax_window_tracker: windowed max/min over a sample stream via one shared comparator; MINMAX_TIE_COUNT_EN enables tie counting
module minmax_window_tracker
  import minmax_window_tracker_pkg::*;
#(
  parameter int WIN_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic              cmp_x,
  input  logic              cmp_y,
  input  logic              cmp_z,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  tie_cnt,
  output logic              flag_err
);
  state_t state, state_nx;
  logic [DATA_W-1:0] max_r, min_r, smp_r;
  logic [CNT_W-1:0] cnt;
  logic in_fire, out_fire, last;
  assign in_ready = (state == S_IDLE) || (state == S_WAIT);
  assign out_valid = state == S_DONE;
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last = (cnt + CNT_W'(1)) == CNT_W'(WIN_LEN);
  assign cmp_a = smp_r;
  assign cmp_b = (state == S_CMP_MIN) ? min_r : max_r;
  assign out_max = max_r;
  assign out_min = min_r;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  // next-state: accept, compare against max, compare against min, then present result
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (in_fire) state_nx = (WIN_LEN == 1) ? S_DONE : S_WAIT;
      S_WAIT:    if (in_fire) state_nx = S_CMP_MAX;
      S_CMP_MAX: state_nx = S_CMP_MIN;
      S_CMP_MIN: state_nx = last ? S_DONE : S_WAIT;
      S_DONE:    if (out_fire) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end
  // datapath: first sample seeds both extremes, later samples update on strict flags only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      max_r <= '0;
      min_r <= '0;
      smp_r <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_fire) begin
          max_r <= in_data;
          min_r <= in_data;
          smp_r <= in_data;
          cnt   <= CNT_W'(1);
        end
        S_WAIT:    if (in_fire) smp_r <= in_data;
        S_CMP_MAX: if (cmp_x) max_r <= smp_r;
        S_CMP_MIN: begin
          if (cmp_z) min_r <= smp_r;
          cnt <= cnt + CNT_W'(1);
        end
        S_DONE:    if (out_fire) cnt <= '0;
        default: ;
      endcase
    end
`ifdef MINMAX_TIE_COUNT_EN
  logic [CNT_W-1:0] tie_r;
  assign tie_cnt = tie_r;
  // count samples equal to the running max, saturating, cleared when the result is taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tie_r <= '0;
    else if (out_fire) tie_r <= '0;
    else if (state == S_CMP_MAX && cmp_y && tie_r != '1) tie_r <= tie_r + CNT_W'(1);
`else
  assign tie_cnt = '0;
`endif
  minmax_flag_check u_flag_check (
    .clk    (clk),
    .rst_n  (rst_n),
    .active ((state == S_CMP_MAX) || (state == S_CMP_MIN)),
    .x      (cmp_x),
    .y      (cmp_y),
    .z      (cmp_z),
    .err    (flag_err)
  );
endmodule

// File: tb/tb_minmax_window_tracker.sv
// tb_minmax_window_tracker: randomized self-checking bench with a queue-based window model
module tb_minmax_window_tracker;
  localparam int WL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] cmp_a, cmp_b;
  logic cmp_x, cmp_y, cmp_z;
  logic [7:0] out_max, out_min, tie_cnt;
  logic out_valid, out_ready, flag_err;
  logic inj = 1'b0;
  logic rand_ready = 1'b0;
  logic ready_set = 1'b1;
  logic rnd_ready = 1'b1;
  int total = 0;
  int bad = 0;
  bit exp_err = 0;

  always #5 clk = ~clk;

  // the real 8-bit signed comparator, with a fault-injection override on x and z
  assign cmp_x = ($signed(cmp_a) > $signed(cmp_b)) | inj;
  assign cmp_y = cmp_a == cmp_b;
  assign cmp_z = ($signed(cmp_a) < $signed(cmp_b)) | inj;
  assign out_ready = rand_ready ? rnd_ready : ready_set;

  minmax_window_tracker #(.WIN_LEN(WL)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_z(cmp_z),
    .out_max(out_max), .out_min(out_min), .out_valid(out_valid), .out_ready(out_ready),
    .tie_cnt(tie_cnt), .flag_err(flag_err)
  );

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  typedef struct { logic [7:0] mx; logic [7:0] mn; logic [7:0] tie; } res_t;
  logic signed [7:0] cur[$];
  res_t expq[$];
  logic signed [7:0] m_mx, m_mn;
  int m_tie;
  res_t m_r;

  // model: gather accepted samples into windows, derive max/min/ties, and check every visible result
  always @(negedge clk) begin
    if (!rst_n) cur.delete();
    else begin
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (cur.size() == WL) begin
          m_mx = cur[0];
          m_mn = cur[0];
          m_tie = 0;
          for (int i = 1; i < cur.size(); i++) begin
            if (cur[i] == m_mx) m_tie++;
            if (cur[i] > m_mx) m_mx = cur[i];
            if (cur[i] < m_mn) m_mn = cur[i];
          end
`ifndef MINMAX_TIE_COUNT_EN
          m_tie = 0;
`endif
          m_r.mx = m_mx;
          m_r.mn = m_mn;
          m_r.tie = 8'(m_tie);
          expq.push_back(m_r);
          cur.delete();
        end
      end
      chk("flag_err", flag_err, exp_err);
      if (out_valid) begin
        if (expq.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          chk("out_max", out_max, expq[0].mx);
          chk("out_min", out_min, expq[0].mn);
          chk("tie_cnt", tie_cnt, expq[0].tie);
          if (out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 rnd_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1);
  end

  task automatic send(input logic [7:0] v);
    bit ok = 0;
    in_data = v;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    bit ok = 0;
    lat = 0;
    while (lat < 60 && !ok) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) ok = 1;
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  logic [7:0] bnd[4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};
  logic [7:0] s4[4];
  logic [7:0] h_mx, h_mn;
  bit pat[7];
  int lat, idx, cyc;

  initial begin
    // reset state
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_max", out_max, 0);
    chk("rst_min", out_min, 0);
    chk("rst_tie", tie_cnt, 0);
    chk("rst_err", flag_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    // 1: basic window and latency
    send(8'd5); send(8'hFD); send(8'd7); send(8'd0);
    wait_valid(lat);
    chk("t1_latency", lat, 2);
    chk("t1_max", out_max, 8'h07);
    chk("t1_min", out_min, 8'hFD);
    @(posedge clk); #1;
    // 2: all most-negative samples
    repeat (4) send(8'h80);
    wait_valid(lat);
    chk("t2_max", out_max, 8'h80);
    chk("t2_min", out_min, 8'h80);
`ifdef MINMAX_TIE_COUNT_EN
    chk("t2_tie", tie_cnt, 3);
`else
    chk("t2_tie", tie_cnt, 0);
`endif
    @(posedge clk); #1;
    // 3: back-pressure holds the result
    ready_set = 1'b0;
    repeat (4) send(8'($urandom));
    wait_valid(lat);
    h_mx = out_max;
    h_mn = out_min;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t3_valid_held", out_valid, 1);
      chk("t3_in_ready", in_ready, 0);
      chk("t3_max_stable", out_max, h_mx);
      chk("t3_min_stable", out_min, h_mn);
    end
    ready_set = 1'b1;
    @(posedge clk); #1;
    chk("t3_released", out_valid, 0);
    chk("t3_idle_ready", in_ready, 1);
    // 4: in_valid held high, observe acceptance pattern
    for (int i = 0; i < 4; i++) s4[i] = 8'($urandom);
    in_valid = 1'b1;
    in_data = s4[0];
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(negedge clk);
      if (cyc < 7) pat[cyc] = in_ready;
      if (in_ready) idx++;
      @(posedge clk);
      #1 if (idx < 4) in_data = s4[idx];
      else in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    chk("t4_p0", pat[0], 1); chk("t4_p1", pat[1], 1); chk("t4_p2", pat[2], 0);
    chk("t4_p3", pat[3], 0); chk("t4_p4", pat[4], 1); chk("t4_p5", pat[5], 0);
    chk("t4_p6", pat[6], 0);
    wait_valid(lat);
    @(posedge clk); #1;
    // 5: reset in the middle of a compare discards the window
    send(8'd50); send(8'd60);
    @(posedge clk); #1;
    chk("t5_in_cmp", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_max", out_max, 0);
    chk("t5_min", out_min, 0);
    chk("t5_valid", out_valid, 0);
    chk("t5_tie", tie_cnt, 0);
    chk("t5_err", flag_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    wait_valid(lat);
    chk("t5_new_max", out_max, 4);
    chk("t5_new_min", out_min, 1);
    @(posedge clk); #1;
    // random windows with random back-pressure and boundary values
    rand_ready = 1'b1;
    for (int w = 0; w < 30; w++) begin
      for (int k = 0; k < WL; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 send(($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 3)] : 8'($urandom));
      end
    end
    rand_ready = 1'b0;
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(posedge clk);
    #1 chk("drain", expq.size(), 0);
    // 6: fault-inject non-one-hot flags during one compare
    send(8'd1); send(8'd2); send(8'd9);
    inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    exp_err = 1;
    send(8'd3);
    wait_valid(lat);
    chk("t6_max", out_max, 9);
    chk("t6_min", out_min, 1);
    chk("t6_err", flag_err, 1);
    @(posedge clk); #1;
    repeat (4) send(8'd5);
    wait_valid(lat);
    chk("t6_err_sticky", flag_err, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_err = 0;
    #1 chk("t6_err_cleared", flag_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
